// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller and display blocks.
package ttt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StCheck,
    StResult
  } state_e;

  // 2-bit cell field encodings
  localparam logic [1:0] CellEmpty = 2'b00;
  localparam logic [1:0] CellX     = 2'b01;
  localparam logic [1:0] CellO     = 2'b10;

  // Winner encodings
  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinX    = 2'b01;
  localparam logic [1:0] WinO    = 2'b10;
  localparam logic [1:0] WinDraw = 2'b11;

  localparam int unsigned NumCells = 9;
  localparam int unsigned NumLines = 8;

  // Rows 0-2, columns 3-5, diagonal 6, anti-diagonal 7
  localparam int unsigned LineCells [NumLines][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Keypad code 1..9 maps to cell 0..8
  function automatic logic [3:0] cell_idx(input logic [3:0] key);
    return key - 4'd1;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational line detector: flags every line fully owned by the given player.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [17:0] board_i,
  input  logic        player_i,   // 0 = X, 1 = O
  output logic [7:0]  line_done_o,
  output logic        any_win_o
);

  logic [1:0] mark;

  // Compare the three cells of each line against the player's mark
  always_comb begin
    mark        = player_i ? CellO : CellX;
    line_done_o = '0;
    for (int l = 0; l < NumLines; l++) begin
      line_done_o[l] = (board_i[2*LineCells[l][0] +: 2] == mark) &&
                       (board_i[2*LineCells[l][1] +: 2] == mark) &&
                       (board_i[2*LineCells[l][2] +: 2] == mark);
    end
    any_win_o = |line_done_o;
  end

endmodule

// File: rtl/ttt_turn_ctrl.sv
// Tic-tac-toe game sequencer: validates keypad moves, owns the board, detects win/draw
// and holds the result for the display blocks.
module ttt_turn_ctrl
  import ttt_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter bit          FIRST_O     = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        key_valid,
  input  logic [3:0]  key_data,
  output logic [17:0] board,
  output logic        turn_o,
  output logic        busy,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic [7:0]  win_line,
  output logic        move_err,
  output logic [3:0]  move_count
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [17:0]      board_q, board_d;
  logic             turn_q, turn_d;
  logic [1:0]       winner_q, winner_d;
  logic [7:0]       win_line_q, win_line_d;
  logic             move_err_q, move_err_d;
  logic [3:0]       move_count_q, move_count_d;
  logic [HoldW-1:0] hold_q, hold_d;

  logic       key_in_range;
  logic [3:0] key_cell;
  logic       cell_free;
  logic       key_legal;
  logic       hold_done;
  logic [1:0] mark;
  logic [7:0] line_done;
  logic       any_win;

  // Lines are evaluated for the player who just moved; turn is not toggled until CHECK ends
  ttt_line_check u_line_check (
    .board_i     (board_q),
    .player_i    (turn_q),
    .line_done_o (line_done),
    .any_win_o   (any_win)
  );

  // Decode the key and look up whether its cell is still empty
  always_comb begin
    key_in_range = (key_data >= 4'd1) && (key_data <= 4'd9);
    key_cell     = cell_idx(key_data);
    cell_free    = 1'b0;
    for (int i = 0; i < NumCells; i++) begin
      if (key_cell == 4'(i)) begin
        cell_free = (board_q[2*i +: 2] == CellEmpty);
      end
    end
    key_legal = key_in_range && cell_free;
    hold_done = (hold_q == HoldLast);
    mark      = turn_q ? CellO : CellX;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start restarts the game from any state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StPlay;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StIdle;
        StPlay:   if (key_valid && key_legal) state_d = StCheck;
        StCheck:  state_d = (any_win || move_count_q == 4'd9) ? StResult : StPlay;
        StResult: if (hold_done) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Board, turn, result and hold-counter next-state
  always_comb begin
    board_d      = board_q;
    turn_d       = turn_q;
    winner_d     = winner_q;
    win_line_d   = win_line_q;
    move_count_d = move_count_q;
    move_err_d   = 1'b0;
    hold_d       = '0;
    if (start) begin
      board_d      = '0;
      turn_d       = FIRST_O;
      winner_d     = WinNone;
      win_line_d   = '0;
      move_count_d = '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPlay: begin
          if (key_valid) begin
            if (key_legal) begin
              for (int i = 0; i < NumCells; i++) begin
                if (key_cell == 4'(i)) board_d[2*i +: 2] = mark;
              end
              move_count_d = move_count_q + 4'd1;
            end else begin
              move_err_d = 1'b1;
            end
          end
        end
        StCheck: begin
          if (any_win) begin
            winner_d   = turn_q ? WinO : WinX;
            // Isolate the lowest set bit
            win_line_d = line_done & (~line_done + 8'd1);
          end else if (move_count_q == 4'd9) begin
            winner_d = WinDraw;
          end else begin
            turn_d = ~turn_q;
          end
        end
        StResult: begin
          if (!hold_done) hold_d = hold_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      board_q      <= '0;
      turn_q       <= FIRST_O;
      winner_q     <= WinNone;
      win_line_q   <= '0;
      move_err_q   <= 1'b0;
      move_count_q <= '0;
      hold_q       <= '0;
    end else begin
      board_q      <= board_d;
      turn_q       <= turn_d;
      winner_q     <= winner_d;
      win_line_q   <= win_line_d;
      move_err_q   <= move_err_d;
      move_count_q <= move_count_d;
      hold_q       <= hold_d;
    end
  end

  // Outputs
  always_comb begin
    board      = board_q;
    turn_o     = turn_q;
    busy       = (state_q == StPlay) || (state_q == StCheck);
    game_over  = (state_q == StResult);
    winner     = winner_q;
    win_line   = win_line_q;
    move_err   = move_err_q;
    move_count = move_count_q;
  end

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// Directed bench for ttt_turn_ctrl with an expected-output scoreboard.
module tb_ttt_turn_ctrl;
  import ttt_pkg::*;

  localparam int unsigned Hold = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, key_valid;
  logic [3:0]  key_data;

  logic [17:0] board, b1_board;
  logic        turn_o, busy, game_over, move_err;
  logic        b1_turn, b1_busy, b1_go, b1_err;
  logic [1:0]  winner, b1_winner;
  logic [7:0]  win_line, b1_line;
  logic [3:0]  move_count, b1_cnt;

  ttt_turn_ctrl #(.HOLD_CYCLES(Hold), .FIRST_O(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .board      (board),
    .turn_o     (turn_o),
    .busy       (busy),
    .game_over  (game_over),
    .winner     (winner),
    .win_line   (win_line),
    .move_err   (move_err),
    .move_count (move_count)
  );

  ttt_turn_ctrl #(.HOLD_CYCLES(Hold), .FIRST_O(1'b1)) dut_o (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_valid  (key_valid),
    .key_data   (key_data),
    .board      (b1_board),
    .turn_o     (b1_turn),
    .busy       (b1_busy),
    .game_over  (b1_go),
    .winner     (b1_winner),
    .win_line   (b1_line),
    .move_err   (b1_err),
    .move_count (b1_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [17:0] board;
    logic        turn;
    logic        busy;
    logic        go;
    logic [1:0]  win;
    logic [7:0]  line;
    logic        err;
    logic [3:0]  cnt;
    bit          chk_res;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [17:0] e_board;
  logic        e_turn, e_busy, e_go, e_err;
  logic [1:0]  e_win;
  logic [7:0]  e_line;
  logic [3:0]  e_cnt;

  task automatic cmp(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input bit chk_res);
    sb.push_back('{tag: tag, board: e_board, turn: e_turn, busy: e_busy, go: e_go,
                   win: e_win, line: e_line, err: e_err, cnt: e_cnt, chk_res: chk_res});
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".board"}, board, e.board);
      cmp({e.tag, ".turn_o"}, 18'(turn_o), 18'(e.turn));
      cmp({e.tag, ".busy"}, 18'(busy), 18'(e.busy));
      cmp({e.tag, ".game_over"}, 18'(game_over), 18'(e.go));
      cmp({e.tag, ".move_err"}, 18'(move_err), 18'(e.err));
      if (e.chk_res) begin
        cmp({e.tag, ".winner"}, 18'(winner), 18'(e.win));
        cmp({e.tag, ".win_line"}, 18'(win_line), 18'(e.line));
        cmp({e.tag, ".move_count"}, 18'(move_count), 18'(e.cnt));
      end
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point
  task automatic cycle(input logic s, input logic kv, input logic [3:0] kd);
    start     = s;
    key_valid = kv;
    key_data  = kd;
    @(posedge clk);
    #1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_data  = 4'd0;
  endtask

  task automatic step(input string tag, input logic s, input logic kv, input logic [3:0] kd,
                      input bit chk_res = 1'b1);
    push(tag, chk_res);
    cycle(s, kv, kd);
    pop_check();
  endtask

  task automatic set_reset_exp();
    e_board = '0; e_turn = 1'b0; e_busy = 1'b0; e_go = 1'b0;
    e_win = 2'b00; e_line = 8'h00; e_err = 1'b0; e_cnt = 4'd0;
  endtask

  task automatic do_start(input string tag);
    e_board = '0; e_cnt = 4'd0; e_turn = 1'b0; e_win = 2'b00; e_line = 8'h00;
    e_busy = 1'b1; e_go = 1'b0; e_err = 1'b0;
    step(tag, 1'b1, 1'b0, 4'd0);
  endtask

  // Legal move: mark lands on the key edge, the CHECK edge then either ends or passes the turn
  task automatic do_move(input string tag, input int k, input logic [1:0] res,
                         input logic [7:0] line);
    e_board[(k-1)*2 +: 2] = e_turn ? 2'b10 : 2'b01;
    e_cnt = e_cnt + 4'd1;
    e_err = 1'b0;
    step({tag, "_w"}, 1'b0, 1'b1, 4'(k));
    if (res != 2'b00) begin
      e_win = res; e_line = line; e_go = 1'b1; e_busy = 1'b0;
    end else begin
      e_turn = ~e_turn;
    end
    step({tag, "_c"}, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic do_bad(input string tag, input logic [3:0] k);
    e_err = 1'b1;
    step(tag, 1'b0, 1'b1, k);
    e_err = 1'b0;
    step({tag, "_clr"}, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; key_valid = 1'b0; key_data = 4'd0;
    set_reset_exp();
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b1, 4'd5);
    cmp("rst_first_o_turn", 18'(b1_turn), 18'd1);
    rst_n = 1'b1;
    step("idle_key_ignored", 1'b0, 1'b1, 4'd5);

    // X wins on row 0
    do_start("xrow_start");
    do_move("xrow_k1", 1, 2'b00, 8'h00);
    do_move("xrow_k4", 4, 2'b00, 8'h00);
    do_move("xrow_k2", 2, 2'b00, 8'h00);
    do_move("xrow_k5", 5, 2'b00, 8'h00);
    do_move("xrow_k3", 3, 2'b01, 8'h01);
    cmp("xrow_board_const", board, 18'h00295);
    cmp("xrow_count", 18'(move_count), 18'd5);
    step("xrow_key_in_result", 1'b0, 1'b1, 4'd9);

    // Rejected keys, and a key dropped during CHECK
    do_start("ill_start");
    do_move("ill_k5", 5, 2'b00, 8'h00);
    do_bad("ill_again5", 4'd5);
    do_bad("ill_k0", 4'd0);
    do_bad("ill_k12", 4'd12);
    e_board[1:0] = 2'b10; e_cnt = 4'd2;
    step("chk_w", 1'b0, 1'b1, 4'd1);
    e_turn = 1'b0;
    step("chk_drop", 1'b0, 1'b1, 4'd2);
    step("chk_after", 1'b0, 1'b0, 4'd0);

    // Draw, then hold timeout back to IDLE with board retained
    do_start("draw_start");
    do_move("draw_k1", 1, 2'b00, 8'h00);
    do_move("draw_k2", 2, 2'b00, 8'h00);
    do_move("draw_k3", 3, 2'b00, 8'h00);
    do_move("draw_k5", 5, 2'b00, 8'h00);
    do_move("draw_k4", 4, 2'b00, 8'h00);
    do_move("draw_k6", 6, 2'b00, 8'h00);
    do_move("draw_k8", 8, 2'b00, 8'h00);
    do_move("draw_k7", 7, 2'b00, 8'h00);
    do_move("draw_k9", 9, 2'b11, 8'h00);
    cmp("draw_count", 18'(move_count), 18'd9);
    for (int i = 0; i < int'(Hold) - 1; i++) step("draw_hold", 1'b0, 1'b0, 4'd0);
    e_go = 1'b0; e_busy = 1'b0;
    step("draw_idle", 1'b0, 1'b0, 4'd0, 1'b0);

    // O-first instance wins on the anti-diagonal; X-first instance wins the same line
    do_start("o_start");
    do_move("o_k3", 3, 2'b00, 8'h00);
    do_move("o_k1", 1, 2'b00, 8'h00);
    do_move("o_k5", 5, 2'b00, 8'h00);
    do_move("o_k2", 2, 2'b00, 8'h00);
    do_move("o_k7", 7, 2'b01, 8'h80);
    cmp("o_winner", 18'(b1_winner), 18'd2);
    cmp("o_win_line", 18'(b1_line), 18'h80);
    cmp("o_game_over", 18'(b1_go), 18'd1);
    cmp("o_board", b1_board, 18'h02225);
    cmp("o_count", 18'(b1_cnt), 18'd5);

    // Restart mid-game, then reset during RESULT
    do_start("mid_start");
    do_move("mid_k1", 1, 2'b00, 8'h00);
    do_move("mid_k2", 2, 2'b00, 8'h00);
    do_move("mid_k3", 3, 2'b00, 8'h00);
    do_start("mid_restart");
    do_move("mid_r1", 1, 2'b00, 8'h00);
    do_move("mid_r4", 4, 2'b00, 8'h00);
    do_move("mid_r2", 2, 2'b00, 8'h00);
    do_move("mid_r5", 5, 2'b00, 8'h00);
    do_move("mid_r3", 3, 2'b01, 8'h01);
    set_reset_exp();
    rst_n = 1'b0;
    step("rst_in_result", 1'b1, 1'b1, 4'd5);
    rst_n = 1'b1;
    cmp("rst_in_result_first_o", 18'(b1_turn), 18'd1);
    do_start("same_start");
    do_move("same_k1", 1, 2'b00, 8'h00);
    e_board = '0; e_cnt = 4'd0; e_turn = 1'b0; e_busy = 1'b1;
    step("start_key_same", 1'b1, 1'b1, 4'd2);
    step("start_key_after", 1'b0, 1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
